// File: rtl/vga_timing_pkg.sv
// Shared raster timing constants, the decoded sync bundle type and a line/frame total helper.
package vga_timing_pkg;

    localparam int VGA640_H_ACTIVE  = 640;
    localparam int VGA640_H_FP      = 16;
    localparam int VGA640_H_SYNC    = 96;
    localparam int VGA640_H_BP      = 48;
    localparam int VGA640_V_ACTIVE  = 480;
    localparam int VGA640_V_FP      = 10;
    localparam int VGA640_V_SYNC    = 2;
    localparam int VGA640_V_BP      = 33;

    localparam int SVGA800_H_ACTIVE = 800;
    localparam int SVGA800_H_FP     = 40;
    localparam int SVGA800_H_SYNC   = 128;
    localparam int SVGA800_H_BP     = 88;
    localparam int SVGA800_V_ACTIVE = 600;
    localparam int SVGA800_V_FP     = 1;
    localparam int SVGA800_V_SYNC   = 4;
    localparam int SVGA800_V_BP     = 23;

    typedef struct packed {
        logic frame_start;
        logic line_start;
        logic display_on;
        logic vsync;
        logic hsync;
    } sync_t;

    function automatic int total(input int a, input int b, input int c, input int d);
        return a + b + c + d;
    endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Reset-to-inactive shift register aligning the sync bundle; latency DEPTH clk (0 = wire).
// Shifts every clk unconditionally; no backpressure.
module sync_delay_line #(
    parameter int               WIDTH   = 5,
    parameter int               DEPTH   = 0,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    if (DEPTH == 0) begin : g_wire
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ reset;
        assign q = d;
    end else begin : g_pipe
        logic [WIDTH-1:0] stage [DEPTH];

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
            end else begin
                stage[0] <= d;
                for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
            end
        end

        assign q = stage[DEPTH-1];
    end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: prescaled pixel strobe, h/v/frame counters, sync/blank decode.
// Counters lag pix_stb by 1 clk, decoded outputs by PIPE_DLY clk; free-running, no backpressure.
module video_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE = VGA640_H_ACTIVE,
    parameter int   H_FP     = VGA640_H_FP,
    parameter int   H_SYNC   = VGA640_H_SYNC,
    parameter int   H_BP     = VGA640_H_BP,
    parameter int   V_ACTIVE = VGA640_V_ACTIVE,
    parameter int   V_FP     = VGA640_V_FP,
    parameter int   V_SYNC   = VGA640_V_SYNC,
    parameter int   V_BP     = VGA640_V_BP,
    parameter logic H_POL    = 1'b1,
    parameter logic V_POL    = 1'b1,
    parameter int   CNT_W    = 10,
    parameter int   FC_W     = 8,
    parameter int   PIPE_DLY = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [1:0]       clk_div,
    output logic             pix_stb,
    output logic [CNT_W-1:0] hpos,
    output logic [CNT_W-1:0] vpos,
    output logic             hsync,
    output logic             vsync,
    output logic             display_on,
    output logic             line_start,
    output logic             frame_start,
    output logic [FC_W-1:0]  frame_count
);

    localparam int H_TOTAL = total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0 ||
        H_TOTAL > 2**CNT_W || V_TOTAL > 2**CNT_W || PIPE_DLY < 0 || PIPE_DLY > 7) begin : g_bad_params
        $error("video_timing_gen: illegal timing parameters");
    end

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_VIS  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam sync_t SYNC_IDLE = '{frame_start: 1'b0, line_start: 1'b0, display_on: 1'b0,
                                    vsync: ~V_POL, hsync: ~H_POL};

    logic [1:0] presc;

    // A count beyond a freshly lowered clk_div restarts without emitting a strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc   <= 2'd0;
            pix_stb <= 1'b0;
        end else if (!enable) begin
            presc   <= 2'd0;
            pix_stb <= 1'b0;
        end else if (presc >= clk_div) begin
            presc   <= 2'd0;
            pix_stb <= (presc == clk_div);
        end else begin
            presc   <= presc + 2'd1;
            pix_stb <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hpos        <= '0;
            vpos        <= '0;
            frame_count <= '0;
        end else if (pix_stb) begin
            if (hpos == H_LAST) begin
                hpos <= '0;
                if (vpos == V_LAST) begin
                    vpos        <= '0;
                    frame_count <= frame_count + FC_W'(1);
                end else begin
                    vpos <= vpos + CNT_W'(1);
                end
            end else begin
                hpos <= hpos + CNT_W'(1);
            end
        end
    end

    sync_t sync_raw;
    sync_t sync_out;

    // Forced idle during reset so the zero-delay configuration also shows inactive values.
    always_comb begin
        sync_raw = SYNC_IDLE;
        if (!reset) begin
            sync_raw.hsync       = (hpos >= HS_BEG && hpos < HS_END) ? H_POL : ~H_POL;
            sync_raw.vsync       = (vpos >= VS_BEG && vpos < VS_END) ? V_POL : ~V_POL;
            sync_raw.display_on  = (hpos < H_VIS) && (vpos < V_VIS);
            sync_raw.line_start  = pix_stb && (hpos == '0);
            sync_raw.frame_start = pix_stb && (hpos == '0) && (vpos == '0);
        end
    end

    sync_delay_line #(
        .WIDTH   ($bits(sync_t)),
        .DEPTH   (PIPE_DLY),
        .RST_VAL (SYNC_IDLE)
    ) u_sync_delay_line (
        .clk   (clk),
        .reset (reset),
        .d     (sync_raw),
        .q     (sync_out)
    );

    assign hsync       = sync_out.hsync;
    assign vsync       = sync_out.vsync;
    assign display_on  = sync_out.display_on;
    assign line_start  = sync_out.line_start;
    assign frame_start = sync_out.frame_start;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: five configurations share stimulus; a strobe-count model predicts outputs.
`timescale 1ns/1ps
module tb_video_timing_gen;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b1;
    logic [1:0] clk_div = 2'd0;

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // A: default 640x480
    logic a_stb, a_hs, a_vs, a_de, a_ls, a_fs;
    logic [9:0] a_h, a_v;
    logic [7:0] a_fc;
    // B: small timing, CNT_W=4, FC_W=2
    logic b_stb, b_hs, b_vs, b_de, b_ls, b_fs;
    logic [3:0] b_h, b_v;
    logic [1:0] b_fc;
    // C: small timing, active-low syncs
    logic c_stb, c_hs, c_vs, c_de, c_ls, c_fs;
    logic [9:0] c_h, c_v;
    logic [7:0] c_fc;
    // D: small timing, PIPE_DLY=3
    logic d_stb, d_hs, d_vs, d_de, d_ls, d_fs;
    logic [9:0] d_h, d_v;
    logic [7:0] d_fc;
    // E: small horizontal, default vertical
    logic e_stb, e_hs, e_vs, e_de, e_ls, e_fs;
    logic [9:0] e_h, e_v;
    logic [7:0] e_fc;

    video_timing_gen u_a (
        .clk(clk), .reset(reset), .enable(enable), .clk_div(clk_div), .pix_stb(a_stb),
        .hpos(a_h), .vpos(a_v), .hsync(a_hs), .vsync(a_vs), .display_on(a_de),
        .line_start(a_ls), .frame_start(a_fs), .frame_count(a_fc));

    video_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2), .V_ACTIVE(4), .V_FP(1),
        .V_SYNC(1), .V_BP(1), .CNT_W(4), .FC_W(2)) u_b (
        .clk(clk), .reset(reset), .enable(enable), .clk_div(clk_div), .pix_stb(b_stb),
        .hpos(b_h), .vpos(b_v), .hsync(b_hs), .vsync(b_vs), .display_on(b_de),
        .line_start(b_ls), .frame_start(b_fs), .frame_count(b_fc));

    video_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2), .V_ACTIVE(4), .V_FP(1),
        .V_SYNC(1), .V_BP(1), .H_POL(1'b0), .V_POL(1'b0)) u_c (
        .clk(clk), .reset(reset), .enable(enable), .clk_div(clk_div), .pix_stb(c_stb),
        .hpos(c_h), .vpos(c_v), .hsync(c_hs), .vsync(c_vs), .display_on(c_de),
        .line_start(c_ls), .frame_start(c_fs), .frame_count(c_fc));

    video_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2), .V_ACTIVE(4), .V_FP(1),
        .V_SYNC(1), .V_BP(1), .PIPE_DLY(3)) u_d (
        .clk(clk), .reset(reset), .enable(enable), .clk_div(clk_div), .pix_stb(d_stb),
        .hpos(d_h), .vpos(d_v), .hsync(d_hs), .vsync(d_vs), .display_on(d_de),
        .line_start(d_ls), .frame_start(d_fs), .frame_count(d_fc));

    video_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2)) u_e (
        .clk(clk), .reset(reset), .enable(enable), .clk_div(clk_div), .pix_stb(e_stb),
        .hpos(e_h), .vpos(e_v), .hsync(e_hs), .vsync(e_vs), .display_on(e_de),
        .line_start(e_ls), .frame_start(e_fs), .frame_count(e_fc));

    // Model: mc = enabled clks since (re)start, mn = pixel strobes completed, mstb = strobe this clk.
    int         cyc = 0;
    int         mc = 0;
    int         mn = 0;
    bit         mstb = 1'b0;
    logic [4:0] dh [4];

    // Expected {frame_start, line_start, display_on, vsync, hsync} after n strobes.
    function automatic logic [4:0] dec(input int n, input bit stb, input int ha, input int hf,
                                       input int hs, input int hb, input int va, input int vf,
                                       input int vs, input int vb, input bit hp, input bit vp);
        int h;
        int v;
        bit hsa;
        bit vsa;
        h   = n % (ha + hf + hs + hb);
        v   = (n / (ha + hf + hs + hb)) % (va + vf + vs + vb);
        hsa = (h >= ha + hf) && (h < ha + hf + hs);
        vsa = (v >= va + vf) && (v < va + vf + vs);
        return {stb && h == 0 && v == 0, stb && h == 0, h < ha && v < va,
                vsa ? vp : ~vp, hsa ? hp : ~hp};
    endfunction

    function automatic logic [4:0] sdec(input int n, input bit stb, input bit hp, input bit vp);
        return dec(n, stb, 8, 2, 2, 2, 4, 1, 1, 1, hp, vp);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (reset) begin
            mc = 0; mn = 0; mstb = 1'b0;
        end else begin
            if (mstb) mn++;
            if (enable) begin
                mc++;
                mstb = (mc % (int'(clk_div) + 1)) == 0;
            end else begin
                mc = 0; mstb = 1'b0;
            end
        end
        for (int i = 3; i > 0; i--) dh[i] = dh[i-1];
        dh[0] = reset ? 5'b00000 : sdec(mn, mstb, 1'b1, 1'b1);
    endtask

    task automatic release_reset();
        reset = 1'b0;
        dh[0] = sdec(mn, mstb, 1'b1, 1'b1);
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; clk_div = 2'd0;
        repeat (4) tick();
        n_total++; if (a_h !== 10'd0) begin n_bad++; $display("FAIL reset_hpos got=%0d want=0", a_h); end
        n_total++; if (a_v !== 10'd0) begin n_bad++; $display("FAIL reset_vpos got=%0d want=0", a_v); end
        n_total++; if (a_fc !== 8'd0) begin n_bad++; $display("FAIL reset_fc got=%0d want=0", a_fc); end
        n_total++; if (a_stb !== 1'b0) begin n_bad++; $display("FAIL reset_stb got=%b want=0", a_stb); end
        n_total++; if ({a_fs, a_ls, a_de, a_vs, a_hs} !== 5'b00000) begin n_bad++; $display("FAIL reset_sync_a got=%b want=00000", {a_fs, a_ls, a_de, a_vs, a_hs}); end
        n_total++; if ({c_fs, c_ls, c_de, c_vs, c_hs} !== 5'b00011) begin n_bad++; $display("FAIL reset_sync_c got=%b want=00011", {c_fs, c_ls, c_de, c_vs, c_hs}); end
        n_total++; if ({d_fs, d_ls, d_de, d_vs, d_hs} !== 5'b00000) begin n_bad++; $display("FAIL reset_sync_d got=%b want=00000", {d_fs, d_ls, d_de, d_vs, d_hs}); end
    endtask

    task automatic test_default_timing();
        logic [4:0] e;
        int hs_first;
        hs_first = -1;
        release_reset();
        for (int k = 0; k < 1700; k++) begin
            tick();
            e = dec(mn, mstb, 640, 16, 96, 48, 480, 10, 2, 33, 1'b1, 1'b1);
            n_total++; if (a_stb !== mstb) begin n_bad++; $display("FAIL dflt_stb cyc=%0d got=%b want=%b", cyc, a_stb, mstb); end
            n_total++; if (a_h !== 10'(mn % 800)) begin n_bad++; $display("FAIL dflt_hpos cyc=%0d got=%0d want=%0d", cyc, a_h, mn % 800); end
            n_total++; if (a_v !== 10'((mn / 800) % 525)) begin n_bad++; $display("FAIL dflt_vpos cyc=%0d got=%0d want=%0d", cyc, a_v, (mn / 800) % 525); end
            n_total++; if ({a_ls, a_de, a_hs} !== {e[3], e[2], e[0]}) begin n_bad++; $display("FAIL dflt_decode cyc=%0d got=%b want=%b", cyc, {a_ls, a_de, a_hs}, {e[3], e[2], e[0]}); end
            if (a_hs && hs_first < 0) hs_first = int'(a_h);
        end
        n_total++; if (hs_first != 656) begin n_bad++; $display("FAIL dflt_hsync_start got=%0d want=656", hs_first); end
    endtask

    task automatic test_tall_frame();
        logic [4:0] e;
        int last_fs;
        int vs_on;
        bit done;
        last_fs = -1; vs_on = -1; done = 1'b0;
        for (int k = 0; k < 20000 && !done; k++) begin
            tick();
            e = dec(mn, mstb, 8, 2, 2, 2, 480, 10, 2, 33, 1'b1, 1'b1);
            n_total++; if ({e_fs, e_vs} !== {e[4], e[1]}) begin n_bad++; $display("FAIL tall_decode cyc=%0d got=%b want=%b", cyc, {e_fs, e_vs}, {e[4], e[1]}); end
            if (e_vs && vs_on < 0) begin
                vs_on = int'(e_v);
                n_total++; if (e_v !== 10'd490) begin n_bad++; $display("FAIL tall_vsync_start got=%0d want=490", e_v); end
            end
            if (e_fs) begin
                if (last_fs >= 0) begin
                    n_total++; if (cyc - last_fs != 7350) begin n_bad++; $display("FAIL tall_frame_period got=%0d want=7350", cyc - last_fs); end
                end
                last_fs = cyc;
            end
            if (mn > 14701) done = 1'b1;
        end
        n_total++; if (!done) begin n_bad++; $display("FAIL tall_timeout got=%0d strobes want=14702", mn); end
    endtask

    task automatic test_small_div();
        logic [4:0] e;
        int fs_seen;
        int last_stb;
        fs_seen = 0; last_stb = -1;
        reset = 1'b1; clk_div = 2'd2;
        repeat (3) tick();
        release_reset();
        for (int k = 0; k < 1216; k++) begin
            tick();
            e = sdec(mn, mstb, 1'b1, 1'b1);
            n_total++; if (b_stb !== mstb) begin n_bad++; $display("FAIL div_stb cyc=%0d got=%b want=%b", cyc, b_stb, mstb); end
            n_total++; if (b_h !== 4'(mn % 14)) begin n_bad++; $display("FAIL div_hpos cyc=%0d got=%0d want=%0d", cyc, b_h, mn % 14); end
            n_total++; if (b_v !== 4'((mn / 14) % 7)) begin n_bad++; $display("FAIL div_vpos cyc=%0d got=%0d want=%0d", cyc, b_v, (mn / 14) % 7); end
            n_total++; if (b_fc !== 2'((mn / 98) % 4)) begin n_bad++; $display("FAIL div_fc cyc=%0d got=%0d want=%0d", cyc, b_fc, (mn / 98) % 4); end
            n_total++; if (b_fs !== e[4]) begin n_bad++; $display("FAIL div_fs cyc=%0d got=%b want=%b", cyc, b_fs, e[4]); end
            if (b_stb) begin
                if (last_stb >= 0) begin
                    n_total++; if (cyc - last_stb != 3) begin n_bad++; $display("FAIL div_stb_gap got=%0d want=3", cyc - last_stb); end
                end
                last_stb = cyc;
            end
            if (b_fs) fs_seen++;
        end
        n_total++; if (fs_seen != 5) begin n_bad++; $display("FAIL div_fs_count got=%0d want=5", fs_seen); end
        n_total++; if (b_fc !== 2'd0) begin n_bad++; $display("FAIL div_fc_wrap got=%0d want=0", b_fc); end
    endtask

    task automatic test_polarity();
        logic [4:0] e;
        for (int k = 0; k < 300; k++) begin
            tick();
            e = sdec(mn, mstb, 1'b0, 1'b0);
            n_total++; if ({c_de, c_vs, c_hs} !== e[2:0]) begin n_bad++; $display("FAIL pol_decode cyc=%0d got=%b want=%b", cyc, {c_de, c_vs, c_hs}, e[2:0]); end
        end
    endtask

    task automatic test_pipe_delay();
        for (int k = 0; k < 300; k++) begin
            tick();
            n_total++; if ({d_ls, d_de, d_hs} !== {dh[3][3], dh[3][2], dh[3][0]}) begin n_bad++; $display("FAIL dly_decode cyc=%0d got=%b want=%b", cyc, {d_ls, d_de, d_hs}, {dh[3][3], dh[3][2], dh[3][0]}); end
            n_total++; if (d_h !== 10'(mn % 14)) begin n_bad++; $display("FAIL dly_hpos cyc=%0d got=%0d want=%0d", cyc, d_h, mn % 14); end
        end
    endtask

    task automatic test_reset_enable();
        bit found;
        int first;
        found = 1'b0;
        for (int k = 0; k < 2000 && !found; k++) begin
            tick();
            if (mn % 14 == 5 && (mn / 14) % 7 == 3) found = 1'b1;
        end
        n_total++; if (!found) begin n_bad++; $display("FAIL re_seek_timeout got=%0d want=(5,3)", mn); end
        n_total++; if ({b_h, b_v} !== {4'd5, 4'd3}) begin n_bad++; $display("FAIL re_position got=%0d,%0d want=5,3", b_h, b_v); end
        enable = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            n_total++; if (b_stb !== 1'b0) begin n_bad++; $display("FAIL en_low_stb cyc=%0d got=%b want=0", cyc, b_stb); end
            n_total++; if (b_h !== 4'(mn % 14)) begin n_bad++; $display("FAIL en_low_hold cyc=%0d got=%0d want=%0d", cyc, b_h, mn % 14); end
            n_total++; if (d_ls !== dh[3][3]) begin n_bad++; $display("FAIL en_low_drain cyc=%0d got=%b want=%b", cyc, d_ls, dh[3][3]); end
        end
        n_total++; if ({d_fs, d_ls} !== 2'b00) begin n_bad++; $display("FAIL en_low_pulses got=%b want=00", {d_fs, d_ls}); end
        enable = 1'b1;
        first = 0;
        for (int k = 1; k <= 10 && first == 0; k++) begin
            tick();
            if (b_stb) first = k;
        end
        n_total++; if (first != 3) begin n_bad++; $display("FAIL en_resume_latency got=%0d want=3", first); end
        #2 reset = 1'b1;
        #1;
        n_total++; if ({b_h, b_v, b_fc, b_stb} !== 11'd0) begin n_bad++; $display("FAIL async_rst_cnt got=%0d,%0d,%0d,%b want=0,0,0,0", b_h, b_v, b_fc, b_stb); end
        n_total++; if ({d_fs, d_ls, d_de, d_vs, d_hs} !== 5'b00000) begin n_bad++; $display("FAIL async_rst_dly got=%b want=00000", {d_fs, d_ls, d_de, d_vs, d_hs}); end
        n_total++; if ({c_de, c_vs, c_hs} !== 3'b011) begin n_bad++; $display("FAIL async_rst_pol got=%b want=011", {c_de, c_vs, c_hs}); end
        mc = 0; mn = 0; mstb = 1'b0;
        for (int i = 0; i < 4; i++) dh[i] = 5'b00000;
        repeat (2) tick();
        release_reset();
        first = 0;
        for (int k = 1; k <= 10 && first == 0; k++) begin
            tick();
            if (b_stb) first = k;
        end
        n_total++; if (first != 3) begin n_bad++; $display("FAIL rst_resume_latency got=%0d want=3", first); end
        n_total++; if ({b_ls, b_fs, b_h} !== {1'b1, 1'b1, 4'd0}) begin n_bad++; $display("FAIL rst_resume_pulse got=%b,%b,%0d want=1,1,0", b_ls, b_fs, b_h); end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) dh[i] = 5'b00000;
        test_reset();
        test_default_timing();
        test_tall_frame();
        test_small_div();
        test_polarity();
        test_pipe_delay();
        test_reset_enable();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
